// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Keeps the two most recent key codes for a two-digit display.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic       new_key
);

  localparam int unsigned MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       col, col_d;
  logic [3:0]       cols_d;
  logic [3:0]       pat, pat_d;
  logic [1:0]       row, row_d;
  logic [3:0]       s0_d, s1_d;
  logic             new_key_d;
  logic [3:0]       rows_m, rows_s;
  logic             single;
  logic [1:0]       single_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  // Exactly one low row bit qualifies as a single press
  always_comb begin
    single     = 1'b0;
    single_row = 2'd0;
    case (rows_s)
      4'b1110: begin single = 1'b1; single_row = 2'd0; end
      4'b1101: begin single = 1'b1; single_row = 2'd1; end
      4'b1011: begin single = 1'b1; single_row = 2'd2; end
      4'b0111: begin single = 1'b1; single_row = 2'd3; end
      default: begin single = 1'b0; single_row = 2'd0; end
    endcase
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    col_d     = col;
    pat_d     = pat;
    row_d     = row;
    s0_d      = s0;
    s1_d      = s1;
    new_key_d = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_d = '0;
          if (single) begin
            pat_d   = rows_s;
            row_d   = single_row;
            state_d = DEBOUNCE;
          end else begin
            col_d = col + 2'd1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s != pat) begin
          cnt_d   = '0;
          col_d   = col + 2'd1;
          state_d = SCAN;
        end else if (cnt == DEB_LAST) begin
          cnt_d     = '0;
          s1_d      = s0;
          s0_d      = key_code(row, col);
          new_key_d = 1'b1;
          state_d   = HELD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (rows_s == 4'hF) state_d = RELEASE;
      end
      RELEASE: begin
        // Any chatter sends us back to HELD so a bounce never re-registers
        if (rows_s != 4'hF) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt == DEB_LAST) begin
          cnt_d   = '0;
          col_d   = col + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
    cols_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      cnt     <= '0;
      col     <= 2'd0;
      cols    <= 4'b1110;
      pat     <= 4'hF;
      row     <= 2'd0;
      s0      <= 4'h0;
      s1      <= 4'h0;
      new_key <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      col     <= col_d;
      cols    <= cols_d;
      pat     <= pat_d;
      row     <= row_d;
      s0      <= s0_d;
      s1      <= s1_d;
      new_key <= new_key_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a keypad model shorts pressed rows to the driven column.
module tb_keypad_scanner;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  s0;
  logic [3:0]  s1;
  logic        new_key;
  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  logic [3:0] exp_s0, exp_s1;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .rows    (rows),
    .cols    (cols),
    .s0      (s0),
    .s1      (s1),
    .new_key (new_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) is bit r*4+c; a closed key pulls its row low while its column is driven
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    if (new_key) pulses++;
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] col_drive(input int k);
    logic [3:0] one;
    logic [1:0] kk;
    one = 4'b0001;
    kk  = k[1:0];
    return ~(one << kk);
  endfunction

  task automatic wait_pulse(input int budget, input string name);
    int p0;
    p0 = pulses;
    for (int i = 0; i < budget && pulses == p0; i++) step();
    chk(name, int'(pulses != p0), 1);
  endtask

  task automatic wait_cols_change(input int budget, input string name);
    logic [3:0] old;
    bit changed;
    old = cols;
    changed = 1'b0;
    for (int i = 0; i < budget && !changed; i++) begin
      step();
      changed = (cols != old);
    end
    chk(name, int'(changed), 1);
  endtask

  initial begin
    int p0;
    logic [3:0] seen;
    bit ok;

    vecs[0] = '{1, 1, 4'h5, 1000};
    vecs[1] = '{0, 3, 4'hA, 20};
    vecs[2] = '{3, 3, 4'hD, 20};
    vecs[3] = '{2, 2, 4'h9, 20};
    vecs[4] = '{3, 0, 4'hE, 20};
    vecs[5] = '{3, 2, 4'hF, 20};
    vecs[6] = '{2, 3, 4'hC, 20};
    vecs[7] = '{0, 1, 4'h2, 20};

    keys  = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_cols", int'(cols), int'(4'b1110));
    chk("reset_s0", int'(s0), 0);
    chk("reset_s1", int'(s1), 0);
    chk("reset_new_key", int'(new_key), 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("idle_scan_cols", int'(cols), int'(col_drive(i / 4)));
    end
    exp_s0 = 4'h0;
    exp_s1 = 4'h0;

    // Table of single presses: one registration each, s1 tracks the previous code
    for (int v = 0; v < 8; v++) begin
      p0   = pulses;
      keys = '0;
      keys[vecs[v].r*4 + vecs[v].c] = 1'b1;
      wait_pulse(100, "press_detect");
      exp_s1 = exp_s0;
      exp_s0 = vecs[v].code;
      chk("press_s0", int'(s0), int'(exp_s0));
      chk("press_s1", int'(s1), int'(exp_s1));
      for (int h = 0; h < vecs[v].hold; h++) step();
      chk("hold_single_pulse", pulses - p0, 1);
      keys = '0;
      repeat (30) step();
      chk("release_no_pulse", pulses - p0, 1);
    end

    // Bounce on press: key 7 chatters every 3 cycles, then settles
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      keys    = '0;
      keys[8] = ((i / 3) % 2 == 0);
      step();
    end
    chk("bounce_press_quiet", pulses - p0, 0);
    keys    = '0;
    keys[8] = 1'b1;
    wait_pulse(100, "bounce_press_detect");
    exp_s1 = exp_s0;
    exp_s0 = 4'h7;
    chk("bounce_press_s0", int'(s0), int'(exp_s0));
    chk("bounce_press_s1", int'(s1), int'(exp_s1));
    repeat (20) step();
    chk("bounce_press_one_pulse", pulses - p0, 1);
    keys = '0;
    repeat (30) step();

    // Bounce on release: key 0 held, then 5 high / 2 low chatter twice
    p0       = pulses;
    keys     = '0;
    keys[13] = 1'b1;
    wait_pulse(100, "bounce_release_detect");
    exp_s1 = exp_s0;
    exp_s0 = 4'h0;
    chk("bounce_release_s0", int'(s0), int'(exp_s0));
    chk("bounce_release_s1", int'(s1), int'(exp_s1));
    repeat (10) step();
    for (int rep = 0; rep < 2; rep++) begin
      keys = '0;
      repeat (5) step();
      keys[13] = 1'b1;
      repeat (2) step();
    end
    keys = '0;
    chk("chatter_cols_held", int'(cols), int'(4'b1101));
    wait_cols_change(60, "release_resume");
    chk("release_resume_cols", int'(cols), int'(4'b1011));
    chk("bounce_release_one_pulse", pulses - p0, 1);

    // Ghost: B in c3 pressed while 3 in c2 is held
    p0      = pulses;
    keys    = '0;
    keys[2] = 1'b1;
    wait_pulse(100, "ghost_detect");
    exp_s1 = exp_s0;
    exp_s0 = 4'h3;
    chk("ghost_s0", int'(s0), int'(exp_s0));
    chk("ghost_s1", int'(s1), int'(exp_s1));
    keys[7] = 1'b1;
    repeat (40) step();
    chk("ghost_no_second", pulses - p0, 1);
    chk("ghost_cols_held", int'(cols), int'(4'b1011));
    keys = '0;
    wait_cols_change(60, "ghost_release");
    chk("ghost_restart_c3", int'(cols), int'(4'b0111));
    wait_cols_change(20, "ghost_wrap");
    chk("ghost_wrap_c0", int'(cols), int'(4'b1110));
    chk("ghost_pulses", pulses - p0, 1);

    // Two keys in one column: no registration, scanning continues
    p0      = pulses;
    keys    = '0;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    seen    = '0;
    repeat (60) begin
      step();
      for (int k = 0; k < 4; k++) if (cols == col_drive(k)) seen[k] = 1'b1;
    end
    chk("multi_no_pulse", pulses - p0, 0);
    chk("multi_scan_cols", int'(seen), int'(4'hF));
    chk("multi_s0_stable", int'(s0), int'(exp_s0));
    keys = '0;
    repeat (10) step();

    // Reset at debounce count 5 of key 9
    p0 = pulses;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = (cols != 4'b1011); end
    chk("reset9_leave_c2", int'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = (cols == 4'b1011); end
    chk("reset9_enter_c2", int'(ok), 1);
    keys     = '0;
    keys[10] = 1'b1;
    repeat (9) step();
    chk("reset9_cols_held", int'(cols), int'(4'b1011));
    chk("reset9_s0_before", int'(s0), int'(exp_s0));
    reset = 1'b1;
    step();
    chk("reset9_cols", int'(cols), int'(4'b1110));
    chk("reset9_s0", int'(s0), 0);
    chk("reset9_s1", int'(s1), 0);
    chk("reset9_new_key", int'(new_key), 0);
    keys  = '0;
    reset = 1'b0;
    repeat (40) step();
    chk("reset9_no_pulse", pulses - p0, 0);

    // Exact latency: key 1 held through reset, new_key on the 12th cycle after release of reset
    keys    = '0;
    keys[0] = 1'b1;
    reset   = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("latency_new_key", int'(new_key), int'(i == 12));
      chk("latency_cols", int'(cols), int'(4'b1110));
      if (i == 11) chk("latency_s0_before", int'(s0), 0);
    end
    chk("latency_s0", int'(s0), 1);
    chk("latency_s1", int'(s1), 0);
    keys = '0;
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
